// File: rtl/rmii_byte_receiver.sv
// RMII receive deframer: preamble/SFD strip, dibit-to-byte assembly,
// 10M dibit repetition, CRS_DV toggle tolerance, frame end/error report.
module rmii_byte_receiver #(
    parameter logic [1:0] SPEED_CODE_100_MEGABIT = 2'd1,
    parameter logic [1:0] SPEED_CODE_10_MEGABIT  = 2'd0,
    parameter int         PREAMBLE_MIN_DIBITS    = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] rmii_rxd,
    input  logic       rmii_crs_dv,
    input  logic       rmii_rx_er,
    input  logic [1:0] speed_code,
    output logic [8:0] data,
    output logic       data_valid,
    output logic       frame_end,
    output logic       frame_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DROP
    } state_t;

    localparam logic [7:0] PRE_MIN = 8'(PREAMBLE_MIN_DIBITS);

    state_t     state;
    logic       slow;
    logic [3:0] sample_count;
    logic [7:0] pre_count;
    logic [7:0] shift_byte;
    logic [1:0] index;
    logic [1:0] hold;
    logic       low_seen;
    logic       err_flag;
    logic       first_flag;

    logic       strobe;
    logic [7:0] one_shift;
    logic [7:0] held_shift;
    logic [7:0] two_shift;

    assign strobe     = !slow || (sample_count == 4'd4);
    assign one_shift  = {rmii_rxd, shift_byte[7:2]};
    assign held_shift = {hold, shift_byte[7:2]};
    assign two_shift  = {rmii_rxd, held_shift[7:2]};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            slow         <= 1'b0;
            sample_count <= 4'd0;
            pre_count    <= 8'd0;
            shift_byte   <= 8'd0;
            index        <= 2'd0;
            hold         <= 2'd0;
            low_seen     <= 1'b0;
            err_flag     <= 1'b0;
            first_flag   <= 1'b0;
            data         <= 9'd0;
            data_valid   <= 1'b0;
            frame_end    <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            data_valid  <= 1'b0;
            frame_end   <= 1'b0;
            frame_error <= 1'b0;

            // Phase of the 10M sample counter is anchored to carrier rise
            if (state == S_IDLE)
                sample_count <= 4'd0;
            else if (sample_count == 4'd9)
                sample_count <= 4'd0;
            else
                sample_count <= sample_count + 4'd1;

            case (state)
                S_IDLE: begin
                    slow <= (speed_code != SPEED_CODE_100_MEGABIT) &&
                            (speed_code == SPEED_CODE_10_MEGABIT);
                    if (rmii_crs_dv) begin
                        state      <= S_PREAMBLE;
                        pre_count  <= 8'd0;
                        err_flag   <= 1'b0;
                        first_flag <= 1'b1;
                        low_seen   <= 1'b0;
                        index      <= 2'd0;
                    end
                end

                S_PREAMBLE: begin
                    if (strobe) begin
                        if (!rmii_crs_dv) begin
                            state <= S_IDLE;
                        end else begin
                            case (rmii_rxd)
                                2'b00: begin
                                    if (pre_count != 8'd0) begin
                                        state    <= S_DROP;
                                        low_seen <= 1'b0;
                                    end
                                end
                                2'b01: begin
                                    if (pre_count != 8'hFF)
                                        pre_count <= pre_count + 8'd1;
                                end
                                2'b11: begin
                                    low_seen <= 1'b0;
                                    if (pre_count >= PRE_MIN) begin
                                        state <= S_DATA;
                                        index <= 2'd0;
                                    end else begin
                                        state <= S_DROP;
                                    end
                                end
                                default: begin
                                    state    <= S_DROP;
                                    low_seen <= 1'b0;
                                end
                            endcase
                        end
                    end
                end

                S_DATA: begin
                    if (strobe) begin
                        if (rmii_rx_er)
                            err_flag <= 1'b1;
                        if (rmii_crs_dv && !low_seen) begin
                            shift_byte <= one_shift;
                            index      <= index + 2'd1;
                            if (index == 2'd3) begin
                                data       <= {first_flag, one_shift};
                                data_valid <= 1'b1;
                                first_flag <= 1'b0;
                            end
                        end else if (rmii_crs_dv) begin
                            // Commit held dibit and current one together
                            shift_byte <= two_shift;
                            index      <= index + 2'd2;
                            low_seen   <= 1'b0;
                            if (index == 2'd3) begin
                                data       <= {first_flag, held_shift};
                                data_valid <= 1'b1;
                                first_flag <= 1'b0;
                            end else if (index == 2'd2) begin
                                data       <= {first_flag, two_shift};
                                data_valid <= 1'b1;
                                first_flag <= 1'b0;
                            end
                        end else if (!low_seen) begin
                            hold     <= rmii_rxd;
                            low_seen <= 1'b1;
                        end else begin
                            frame_end   <= 1'b1;
                            frame_error <= err_flag || rmii_rx_er ||
                                           (index != 2'd0);
                            low_seen    <= 1'b0;
                            state       <= S_IDLE;
                        end
                    end
                end

                S_DROP: begin
                    if (strobe) begin
                        if (rmii_crs_dv) begin
                            low_seen <= 1'b0;
                        end else if (low_seen) begin
                            low_seen <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            low_seen <= 1'b1;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rmii_byte_receiver.sv
// Directed bench for rmii_byte_receiver: table of frames plus
// hand-written reset sequences.
module tb_rmii_byte_receiver;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [1:0] rmii_rxd;
    logic       rmii_crs_dv;
    logic       rmii_rx_er;
    logic [1:0] speed_code;
    logic [8:0] data;
    logic       data_valid;
    logic       frame_end;
    logic       frame_error;

    rmii_byte_receiver dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rmii_rxd    (rmii_rxd),
        .rmii_crs_dv (rmii_crs_dv),
        .rmii_rx_er  (rmii_rx_er),
        .speed_code  (speed_code),
        .data        (data),
        .data_valid  (data_valid),
        .frame_end   (frame_end),
        .frame_error (frame_error)
    );

    always #10 clock = ~clock;

    typedef struct {
        string       name;
        logic [1:0]  speed;
        int          pre;
        int          nbytes;
        int          extra;
        bit          toggle;
        int          er_dibit;
        logic [31:0] bytes;
        int          exp_n;
        logic [35:0] exp_d;
        int          exp_gap;
        int          exp_end;
        bit          exp_err;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    int         cyc = 0;
    logic [8:0] vq[$];
    int         vc[$];
    int         fe_n = 0;
    bit         fe_err = 1'b0;
    int         fe_cyc = 0;
    int         both = 0;

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (data_valid) begin
            vq.push_back(data);
            vc.push_back(cyc);
        end
        if (frame_end) begin
            fe_n   = fe_n + 1;
            fe_err = frame_error;
            fe_cyc = cyc;
        end
        if (frame_end && data_valid)
            both = both + 1;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_dibit(input logic [1:0] d, input logic dv,
                              input logic er, input int n);
        rmii_rxd    = d;
        rmii_crs_dv = dv;
        rmii_rx_er  = er;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_mon();
        vq.delete();
        vc.delete();
        fe_n = 0;
        both = 0;
    endtask

    task automatic run_vec(input vec_t v);
        int         hold;
        logic [1:0] dib;
        hold = (v.speed == 2'd0) ? 10 : 1;
        clear_mon();
        speed_code = v.speed;
        for (int i = 0; i < v.pre; i++)
            send_dibit(2'b01, 1'b1, 1'b0, hold);
        send_dibit(2'b11, 1'b1, 1'b0, hold);
        for (int i = 0; i < v.nbytes * 4 + v.extra; i++) begin
            dib = 2'b10;
            if (i < v.nbytes * 4)
                dib = v.bytes[2*i +: 2];
            send_dibit(dib, !(v.toggle && (i % 4 == 2)),
                       (i == v.er_dibit), hold);
        end
        send_dibit(2'b00, 1'b0, 1'b0, 2 * hold);
        send_dibit(2'b00, 1'b0, 1'b0, 6 * hold);

        check({v.name, " count"}, vq.size(), v.exp_n);
        for (int k = 0; k < v.exp_n; k++) begin
            if (k < vq.size()) begin
                check($sformatf("%s byte%0d", v.name, k),
                      {23'd0, vq[k]}, {23'd0, v.exp_d[9*k +: 9]});
                if (k > 0)
                    check($sformatf("%s gap%0d", v.name, k),
                          vc[k] - vc[k-1], v.exp_gap);
            end
        end
        check({v.name, " frame_end"}, fe_n, v.exp_end);
        if (v.exp_end != 0 && fe_n != 0) begin
            check({v.name, " frame_error"}, {31'd0, fe_err},
                  {31'd0, v.exp_err});
            if (vc.size() > 0)
                check({v.name, " end_after_data"},
                      {31'd0, fe_cyc > vc[vc.size()-1]}, 32'd1);
        end
        check({v.name, " overlap"}, both, 0);
    endtask

    localparam logic [31:0] B3 = 32'h000F_A355;
    localparam logic [35:0] D3 = {9'h000, 9'h00F, 9'h0A3, 9'h155};

    vec_t vecs[8];

    initial begin
        vecs[0] = '{"100m",    2'd1, 7, 3, 0, 1'b0, -1, B3, 3, D3,  4, 1, 1'b0};
        vecs[1] = '{"10m",     2'd0, 7, 3, 0, 1'b0, -1, B3, 3, D3, 40, 1, 1'b0};
        vecs[2] = '{"toggle",  2'd1, 7, 3, 0, 1'b1, -1, B3, 3, D3,  4, 1, 1'b0};
        vecs[3] = '{"rx_er",   2'd1, 7, 3, 0, 1'b0,  5, B3, 3, D3,  4, 1, 1'b1};
        vecs[4] = '{"partial", 2'd1, 7, 3, 2, 1'b0, -1, B3, 3, D3,  4, 1, 1'b1};
        vecs[5] = '{"shortpre",2'd1, 2, 3, 0, 1'b0, -1, B3, 0, D3,  4, 0, 1'b0};
        vecs[6] = '{"recover", 2'd1, 7, 3, 0, 1'b0, -1, B3, 3, D3,  4, 1, 1'b0};
        vecs[7] = '{"code2",   2'd2, 7, 3, 0, 1'b0, -1, B3, 3, D3,  4, 1, 1'b0};

        reset_n     = 1'b0;
        rmii_rxd    = 2'b00;
        rmii_crs_dv = 1'b0;
        rmii_rx_er  = 1'b0;
        speed_code  = 2'd1;
        repeat (3) @(posedge clock);
        #1;
        check("rst data", {23'd0, data}, 32'd0);
        check("rst data_valid", {31'd0, data_valid}, 32'd0);
        check("rst frame_end", {31'd0, frame_end}, 32'd0);
        check("rst frame_error", {31'd0, frame_error}, 32'd0);
        reset_n = 1'b1;
        send_dibit(2'b00, 1'b0, 1'b0, 4);

        for (int i = 0; i < 8; i++)
            run_vec(vecs[i]);

        // Reset in the middle of the second byte
        clear_mon();
        speed_code = 2'd1;
        for (int i = 0; i < 7; i++)
            send_dibit(2'b01, 1'b1, 1'b0, 1);
        send_dibit(2'b11, 1'b1, 1'b0, 1);
        for (int i = 0; i < 6; i++)
            send_dibit(2'b01, 1'b1, 1'b0, 1);
        reset_n = 1'b0;
        send_dibit(2'b01, 1'b1, 1'b0, 2);
        check("midrst data", {23'd0, data}, 32'd0);
        check("midrst data_valid", {31'd0, data_valid}, 32'd0);
        check("midrst frame_end", {31'd0, frame_end}, 32'd0);
        reset_n = 1'b1;
        send_dibit(2'b00, 1'b0, 1'b0, 20);
        check("midrst count", vq.size(), 1);
        if (vq.size() > 0)
            check("midrst byte0", {23'd0, vq[0]}, 32'h155);
        check("midrst no_end", fe_n, 0);

        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rmii_byte_receiver.md
Name: rmii_byte_receiver

Overview:
RMII receive-side deframer, the counterpart of the transmit byte shipper. It samples RXD[1:0]/CRS_DV from the PHY (50 MHz RMII clock domain) and handles 10 Mb/s dibit repetition. It strips the preamble and SFD, assembles LSB-first dibits into bytes, and presents them to the MAC as a 9-bit stream whose bit 8 flags the first byte of a frame. It also reports frame end and frame errors.

Parameters:
SPEED_CODE_100_MEGABIT, 1, speed_code value for 100 Mb/s (one dibit per clock)
SPEED_CODE_10_MEGABIT, 0, speed_code value for 10 Mb/s (each dibit held 10 clocks)
PREAMBLE_MIN_DIBITS, 4, minimum count of 01 dibits required before the SFD dibit 11

Ports:
clock  input  1  RMII reference clock, 50 MHz
reset_n  input  1  synchronous, active-low reset
rmii_rxd  input  2  PHY receive dibit
rmii_crs_dv  input  1  PHY carrier sense / data valid
rmii_rx_er  input  1  PHY receive error
speed_code  input  2  link speed; any value other than the 10M code is treated as 100M
data  output  9  [7:0] received byte; [8]=1 on first byte of frame
data_valid  output  1  one-cycle pulse qualifying data
frame_end  output  1  one-cycle pulse at end of an accepted frame
frame_error  output  1  valid with frame_end: rx_er seen or trailing partial byte

Behaviour:
- Reset: state S_IDLE; data=0, data_valid=0, frame_end=0, frame_error=0; all counters, shift register and flags cleared. A reset mid-frame discards the frame and emits no frame_end.
- No backpressure. data_valid and frame_end are pulses; all outputs are registered.
- Sample strobe:
  - 100M: every clock.
  - 10M: a 0..9 sample counter is cleared when crs_dv is first seen high in S_IDLE. The strobe fires at count 4, then every 10 clocks.
  - speed_code is latched in S_IDLE only. It is ignored for the rest of the frame.
- S_IDLE: wait for crs_dv=1, then go to S_PREAMBLE with preamble count=0, error flag=0, first-byte flag=1.
- S_PREAMBLE, per strobe:
  - dibit 00 before any 01: ignored.
  - 01: increment preamble count, saturating at 255.
  - 11 with count >= PREAMBLE_MIN_DIBITS: go to S_DATA, dibit index=0.
  - 11 with count below minimum, or dibit 10: go to S_DROP.
  - crs_dv low at a strobe: return to S_IDLE, no output.
- S_DATA, per strobe with crs_dv=1:
  - Shift the dibit into byte[7:6]; the first dibit lands in bits [1:0] after 4 shifts. Increment the index modulo 4.
  - At index 3: on the next clock, data={first_flag,byte} and data_valid=1; then clear first_flag.
- rmii_rx_er=1 at any strobe in S_DATA sets the error flag. Data is still delivered.
- CRS_DV toggle tolerance (first strobe with crs_dv=0 in S_DATA):
  - Store rxd in a hold register and set low_seen.
  - Next strobe crs_dv=1: commit the held dibit, then the current dibit (two shifts in one cycle). At most one byte is emitted; if the first shift completes a byte, the second shift starts the next byte. Clear low_seen.
  - Next strobe crs_dv=0: frame ends and the held dibit is discarded.
- Frame end: on the clock after the end is detected, frame_end=1 and frame_error = error flag OR (index != 0), then go to S_IDLE. Dibit index is counted excluding the discarded held dibit.
- A frame with zero complete bytes still produces frame_end. frame_error=1 if the index is nonzero, else 0.
- S_DROP: wait for two consecutive strobes with crs_dv=0, then go to S_IDLE. No data_valid or frame_end.
- frame_end never coincides with data_valid; the last byte's data_valid is always at least one clock earlier.

Test Plan:
- 100M: 7x dibit 01, dibit 11, bytes 0x55,0xA3,0x0F as LSB-first dibits, crs_dv low 2 clocks -> data 0x155,0x0A3,0x00F on three pulses 4 clocks apart; frame_end=1, frame_error=0.
- 10M: the same frame with each dibit held 10 clocks -> identical bytes, data_valid pulses 40 clocks apart, frame_end=1, frame_error=0.
- 100M: crs_dv toggles low for single clocks on alternate nibbles mid-frame -> byte stream unchanged; final two-low end -> frame_end, frame_error=0.
- rx_er pulsed for one strobe during byte 2 -> all bytes delivered; frame_end with frame_error=1.
- Frame ends after 2 dibits of a 4th byte -> 3 bytes delivered; frame_error=1.
- Only 2x dibit 01 before 11 -> no data_valid, no frame_end; the next valid frame is received normally. Reset asserted mid-frame -> outputs 0, no frame_end.
